load_access_unit: RTL and testbench
===================================

# load_access_unit

Sequential load unit for the MEM stage: accepts one load request at a time and checks its alignment. It issues an aligned read on a variable-latency data bus, then extracts and sign- or zero-extends the addressed lane. The result returns to the pipeline through a valid/ready handshake. It replaces single-cycle combinational load extension, adding parametrised data width, bus handshaking, AdEL detection and pipeline flush.

## Interface
- DATA_W, 32: bus/result width; legal values 32 or 64.
- ADDR_W, 32: byte-address width.
- TAG_W, 5: destination tag carried with the request.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept; high exactly in IDLE.
- req_addr  in  ADDR_W  byte address.
- req_type  in  3  000 full width, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw (sign-ext), 110 lwu, 111 illegal.
- req_tag  in  TAG_W  destination tag.
- flush  in  1  kill the in-flight load.
- mem_rd_en  out  1  bus read request; held until mem_ack.
- mem_addr  out  ADDR_W  req_addr with low LB = log2(DATA_W/8) bits cleared.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  DATA_W  read data, little-endian lanes.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_data  out  DATA_W  extended load result; 0 when resp_exc.
- resp_tag  out  TAG_W  tag of the request.
- resp_exc  out  1  address-error (AdEL) or illegal type.

## Operation
- States: IDLE, MEM, DRAIN, RESP. Reset → IDLE. All registered outputs and latches reset to 0; req_ready=1 in IDLE, including while reset is held.
- IDLE: a request is accepted on req_valid && !flush. Accepting latches addr, type and tag.
- Accepted request with a legal type and aligned address → MEM.
  - Alignment: half needs addr[0]=0. Word (101/110, or 000 at DATA_W=32) needs addr[1:0]=0. 000 at DATA_W=64 needs addr[2:0]=0.
- Accepted request that is misaligned, has type 111, or has type 101/110 at DATA_W=32 → RESP with resp_exc=1 and resp_data=0. No bus access occurs.
- MEM: mem_rd_en=1 with mem_addr stable.
  - On mem_ack: capture the extracted result → RESP.
  - flush without mem_ack → DRAIN. flush with mem_ack → IDLE, data discarded.
- DRAIN: mem_rd_en stays 1, because bus reads cannot be cancelled. On mem_ack → IDLE, data discarded, no response.
- RESP: resp_valid=1; data, tag and exc held stable.
  - resp_ready → IDLE.
  - flush → IDLE with no handshake. flush wins over resp_ready.
- Extraction: lane offset o = addr[LB-1:0].
  - Byte = mem_rdata[8o +: 8]. Half = mem_rdata[8o +: 16]. Word = mem_rdata[8o +: 32].
  - Signed types replicate the MSB up to DATA_W; unsigned types zero-fill. Type 000 passes mem_rdata unchanged.
- Reset asserted in any state returns immediately to IDLE with all outputs cleared. A bus ack that arrives after reset is ignored.

## Timing
- Accept at edge N. mem_rd_en is high from cycle N+1 until the cycle of mem_ack (cycle M, inclusive).
- resp_valid rises at M+1: minimum latency is 2 cycles accept-to-response with a zero-wait ack.
- Exception path: resp_valid at N+1, mem_rd_en never asserted.
- Throughput is one load per (bus latency + 2) cycles. req_ready is low from N+1 until the cycle after the resp handshake or flush completes.
- flush takes effect at the same edge it is sampled.

## Test plan
- DATA_W=32, lb at 0x1001, mem_rdata=0x0123FDEC with ack 3 cycles after mem_rd_en → mem_addr=0x1000, resp_data=0xFFFFFFFD, resp_exc=0. lbu at the same address → 0x000000FD. lh at 0x1002 → 0x00000123.
- lh at 0x1001, and type 101 at DATA_W=32 → resp_valid at N+1, resp_exc=1, resp_data=0, mem_rd_en never high; tag echoed.
- DATA_W=64, lw at 0x2004, mem_rdata=0x89ABCDEF01234567 → mem_addr=0x2000, resp_data=0xFFFFFFFF89ABCDEF. lwu at the same address → 0x0000000089ABCDEF. Full load at 0x2004 → exc.
- flush one cycle into a 4-cycle bus wait → mem_rd_en held until ack, no resp_valid, req_ready=1 the cycle after ack. Next load completes normally.
- resp_ready held low 3 cycles → resp_valid and resp_data stable throughout, req_ready low. resp_ready high → IDLE on the next cycle.
- reset pulsed mid-MEM → mem_rd_en, resp_valid and resp_exc drop to 0 asynchronously. A later ack is ignored and no response appears.

Source files
------------

// File: rtl/load_access_unit_if.sv
// Bundle of the load unit's request, data-bus and response channels.
// The slave modport is the load unit; master is the pipeline/bus side.
interface load_access_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_type;
  logic [TAG_W-1:0]  req_tag;
  logic              flush;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_exc;

  modport master (
    output req_valid, req_addr, req_type, req_tag, flush,
    output mem_ack, mem_rdata, resp_ready,
    input  req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, resp_tag, resp_exc
  );

  modport slave (
    input  req_valid, req_addr, req_type, req_tag, flush,
    input  mem_ack, mem_rdata, resp_ready,
    output req_ready, mem_rd_en, mem_addr, resp_valid, resp_data, resp_tag, resp_exc
  );
endinterface

// File: rtl/load_access_unit.sv
// MEM-stage load unit: alignment check, aligned bus read, lane extraction with
// sign/zero extension, and a valid/ready response with flush support.
module load_access_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input logic              clk,
  input logic              reset,
  load_access_unit_if.slave bus
);
  localparam int unsigned LB = (DATA_W == 64) ? 3 : 2;

  localparam logic [2:0] T_FULL = 3'b000;
  localparam logic [2:0] T_LB   = 3'b001;
  localparam logic [2:0] T_LBU  = 3'b010;
  localparam logic [2:0] T_LH   = 3'b011;
  localparam logic [2:0] T_LHU  = 3'b100;
  localparam logic [2:0] T_LW   = 3'b101;
  localparam logic [2:0] T_LWU  = 3'b110;

  typedef enum logic [1:0] {IDLE, MEM, DRAIN, RESP} state_t;

  state_t        state;
  logic [LB-1:0] off;
  logic [2:0]    ltype;

  logic              req_ok_c;
  logic [31:0]       lane_c;
  logic [DATA_W-1:0] ext_c;

  // Legal type with a naturally aligned address; word loads need a 64-bit bus.
  always_comb begin
    req_ok_c = 1'b0;
    case (bus.req_type)
      T_FULL:       req_ok_c = (bus.req_addr[LB-1:0] == '0);
      T_LB, T_LBU:  req_ok_c = 1'b1;
      T_LH, T_LHU:  req_ok_c = ~bus.req_addr[0];
      T_LW, T_LWU:  req_ok_c = (DATA_W == 64) && (bus.req_addr[1:0] == 2'b00);
      default:      req_ok_c = 1'b0;
    endcase
  end

  assign lane_c = 32'(bus.mem_rdata >> {off, 3'b000});

  always_comb begin
    ext_c = bus.mem_rdata;
    case (ltype)
      T_LB:    ext_c = DATA_W'($signed(lane_c[7:0]));
      T_LBU:   ext_c = DATA_W'(lane_c[7:0]);
      T_LH:    ext_c = DATA_W'($signed(lane_c[15:0]));
      T_LHU:   ext_c = DATA_W'(lane_c[15:0]);
      T_LW:    ext_c = DATA_W'($signed(lane_c[31:0]));
      T_LWU:   ext_c = DATA_W'(lane_c[31:0]);
      default: ext_c = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      off            <= '0;
      ltype          <= '0;
      bus.req_ready  <= 1'b1;
      bus.mem_rd_en  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_tag   <= '0;
      bus.resp_exc   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            bus.req_ready <= 1'b0;
            off           <= bus.req_addr[LB-1:0];
            ltype         <= bus.req_type;
            bus.resp_tag  <= bus.req_tag;
            bus.mem_addr  <= {bus.req_addr[ADDR_W-1:LB], LB'(0)};
            if (req_ok_c) begin
              state         <= MEM;
              bus.mem_rd_en <= 1'b1;
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_exc   <= 1'b1;
              bus.resp_data  <= '0;
            end
          end
        end
        MEM: begin
          if (bus.mem_ack) begin
            bus.mem_rd_en <= 1'b0;
            if (bus.flush) begin
              state         <= IDLE;
              bus.req_ready <= 1'b1;
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_exc   <= 1'b0;
              bus.resp_data  <= ext_c;
            end
          end else if (bus.flush) begin
            state <= DRAIN;
          end
        end
        // Bus reads cannot be cancelled: wait out the ack and drop the data.
        DRAIN: begin
          if (bus.mem_ack) begin
            state         <= IDLE;
            bus.mem_rd_en <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        RESP: begin
          if (bus.flush || bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_exc   <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_access_unit.sv
// Bench for load_access_unit: 32- and 64-bit instances, directed cases and
// randomized loads checked against an arithmetic reference model.
module tb_load_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        sel64;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [4:0]  req_tag;
  logic        flush;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        resp_ready;

  logic [63:0] o_req_ready, o_mem_rd_en, o_mem_addr, o_resp_valid;
  logic [63:0] o_resp_data, o_resp_tag, o_resp_exc;

  int errors = 0;
  int checks = 0;

  load_access_unit_if #(.DATA_W(32), .ADDR_W(32), .TAG_W(5)) if32 ();
  load_access_unit_if #(.DATA_W(64), .ADDR_W(32), .TAG_W(5)) if64 ();

  load_access_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .bus(if32));
  load_access_unit #(.DATA_W(64), .ADDR_W(32), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .bus(if64));

  always #5 clk = ~clk;

  // Only the selected instance sees requests and acks; the other stays idle.
  assign if32.req_valid  = req_valid & ~sel64;
  assign if32.req_addr   = req_addr;
  assign if32.req_type   = req_type;
  assign if32.req_tag    = req_tag;
  assign if32.flush      = flush & ~sel64;
  assign if32.mem_ack    = mem_ack & ~sel64;
  assign if32.mem_rdata  = mem_rdata[31:0];
  assign if32.resp_ready = resp_ready & ~sel64;
  assign if64.req_valid  = req_valid & sel64;
  assign if64.req_addr   = req_addr;
  assign if64.req_type   = req_type;
  assign if64.req_tag    = req_tag;
  assign if64.flush      = flush & sel64;
  assign if64.mem_ack    = mem_ack & sel64;
  assign if64.mem_rdata  = mem_rdata;
  assign if64.resp_ready = resp_ready & sel64;

  assign o_req_ready  = 64'(sel64 ? if64.req_ready  : if32.req_ready);
  assign o_mem_rd_en  = 64'(sel64 ? if64.mem_rd_en  : if32.mem_rd_en);
  assign o_mem_addr   = 64'(sel64 ? if64.mem_addr   : if32.mem_addr);
  assign o_resp_valid = 64'(sel64 ? if64.resp_valid : if32.resp_valid);
  assign o_resp_data  = sel64 ? if64.resp_data : 64'(if32.resp_data);
  assign o_resp_tag   = 64'(sel64 ? if64.resp_tag   : if32.resp_tag);
  assign o_resp_exc   = 64'(sel64 ? if64.resp_exc   : if32.resp_exc);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t, w=%0d)", name, got, exp, $time, sel64 ? 64 : 32);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: size/sign from the type, offset modulo bus bytes, shift-and-mask.
  function automatic void ref_load(input int w, input logic [31:0] addr, input logic [2:0] t,
                                   input logic [63:0] rd, output logic exc, output logic [63:0] data);
    int nb, size, off;
    bit sgn;
    logic [63:0] v, mask, wmask;
    nb    = w / 8;
    off   = int'(addr[2:0]) % nb;
    wmask = (w == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
    sgn   = 1'b0;
    case (t)
      3'd0:    size = nb;
      3'd1:    begin size = 1; sgn = 1'b1; end
      3'd2:    size = 1;
      3'd3:    begin size = 2; sgn = 1'b1; end
      3'd4:    size = 2;
      3'd5:    begin size = 4; sgn = 1'b1; end
      3'd6:    size = 4;
      default: size = 0;
    endcase
    if ((t == 3'd5 || t == 3'd6) && w == 32) size = 0;
    exc  = (size == 0) || ((off % size) != 0);
    data = '0;
    if (!exc) begin
      if (t == 3'd0) data = rd & wmask;
      else begin
        mask = (64'd1 << (8 * size)) - 64'd1;
        v    = (rd >> (8 * off)) & mask;
        if (sgn && v[8 * size - 1]) v = v | ~mask;
        data = v & wmask;
      end
    end
  endfunction

  // One load from an idle unit: optional bus wait, response stall, handshake.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] t, input logic [4:0] tg,
                         input logic [63:0] rd, input int lat, input int stall,
                         output logic [63:0] got);
    logic e;
    logic [63:0] d;
    int w;
    w = sel64 ? 64 : 32;
    ref_load(w, addr, t, rd, e, d);
    check("ready_before", o_req_ready, 64'd1);
    req_valid = 1'b1; req_addr = addr; req_type = t; req_tag = tg;
    mem_rdata = {$urandom, $urandom};
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_type = 3'($urandom); req_tag = 5'($urandom);
    if (!e) begin
      check("rd_en", o_mem_rd_en, 64'd1);
      check("mem_addr", o_mem_addr, 64'(addr & ~32'(w / 8 - 1)));
      check("no_resp_early", o_resp_valid, 64'd0);
      for (int i = 0; i < lat; i++) begin
        mem_rdata = {$urandom, $urandom};
        tick();
        check("rd_en_hold", o_mem_rd_en, 64'd1);
      end
      mem_ack = 1'b1; mem_rdata = rd;
      tick();
      mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
    end
    check("resp_valid", o_resp_valid, 64'd1);
    check("resp_exc", o_resp_exc, 64'(e));
    check("resp_data", o_resp_data, d);
    check("resp_tag", o_resp_tag, 64'(tg));
    check("rd_en_off", o_mem_rd_en, 64'd0);
    check("ready_busy", o_req_ready, 64'd0);
    got = o_resp_data;
    resp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", o_resp_valid, 64'd1);
      check("stall_data", o_resp_data, d);
      check("stall_ready", o_req_ready, 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_done", o_resp_valid, 64'd0);
    check("ready_after", o_req_ready, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    reset = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_addr = '0; req_type = '0; req_tag = '0;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #1;
      check("rst_ready", o_req_ready, 64'd1);
      check("rst_rd_en", o_mem_rd_en, 64'd0);
      check("rst_valid", o_resp_valid, 64'd0);
      check("rst_exc", o_resp_exc, 64'd0);
      check("rst_data", o_resp_data, 64'd0);
      check("rst_addr", o_mem_addr, 64'd0);
    end
    tick();
    reset = 1'b0; sel64 = 1'b0;
    tick();

    // 32-bit directed extraction and exceptions
    do_load(32'h1001, 3'b001, 5'd3, 64'h0123FDEC, 3, 0, got);
    check("lb_const", got, 64'hFFFF_FFFD);
    do_load(32'h1001, 3'b010, 5'd4, 64'h0123FDEC, 3, 0, got);
    check("lbu_const", got, 64'h0000_00FD);
    do_load(32'h1002, 3'b011, 5'd5, 64'h0123FDEC, 0, 0, got);
    check("lh_const", got, 64'h0000_0123);
    do_load(32'h1001, 3'b011, 5'd6, 64'h0123FDEC, 0, 0, got);
    check("lh_misalign_data", got, 64'd0);
    do_load(32'h1000, 3'b101, 5'd7, 64'h0123FDEC, 0, 0, got);
    check("lw32_exc_data", got, 64'd0);

    // 64-bit directed
    sel64 = 1'b1;
    tick();
    do_load(32'h2004, 3'b101, 5'd8, 64'h89AB_CDEF_0123_4567, 1, 0, got);
    check("lw64_const", got, 64'hFFFF_FFFF_89AB_CDEF);
    do_load(32'h2004, 3'b110, 5'd9, 64'h89AB_CDEF_0123_4567, 2, 0, got);
    check("lwu64_const", got, 64'h0000_0000_89AB_CDEF);
    do_load(32'h2004, 3'b000, 5'd10, 64'h89AB_CDEF_0123_4567, 0, 0, got);
    check("full64_misalign", got, 64'd0);

    // Flush one cycle into a 4-cycle bus wait
    sel64 = 1'b0;
    tick();
    req_valid = 1'b1; req_addr = 32'h1000; req_type = 3'b001; req_tag = 5'd11;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drain_rd_en", o_mem_rd_en, 64'd1);
      check("drain_no_resp", o_resp_valid, 64'd0);
      check("drain_ready", o_req_ready, 64'd0);
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("drain_done_rd_en", o_mem_rd_en, 64'd0);
    check("drain_done_resp", o_resp_valid, 64'd0);
    check("drain_done_ready", o_req_ready, 64'd1);
    tick();
    check("drain_still_no_resp", o_resp_valid, 64'd0);
    do_load(32'h1003, 3'b001, 5'd12, 64'h8000_0000, 1, 3, got);
    check("after_flush_const", got, 64'hFFFF_FF80);

    // Flush together with ack discards the data
    req_valid = 1'b1; req_addr = 32'h1004; req_type = 3'b000; req_tag = 5'd13;
    tick();
    req_valid = 1'b0; flush = 1'b1; mem_ack = 1'b1;
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    check("flush_ack_resp", o_resp_valid, 64'd0);
    check("flush_ack_rd_en", o_mem_rd_en, 64'd0);
    check("flush_ack_ready", o_req_ready, 64'd1);

    // Flush in RESP (with and without resp_ready) and flush blocking accept
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_addr = 32'h1000; req_type = 3'b111; req_tag = 5'd14;
      tick();
      req_valid = 1'b0;
      check("ill_resp", o_resp_valid, 64'd1);
      flush = 1'b1; resp_ready = (k == 1);
      tick();
      flush = 1'b0; resp_ready = 1'b0;
      check("resp_flush_valid", o_resp_valid, 64'd0);
      check("resp_flush_ready", o_req_ready, 64'd1);
    end
    req_valid = 1'b1; flush = 1'b1; req_type = 3'b001;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_ready", o_req_ready, 64'd1);
    check("idle_flush_rd_en", o_mem_rd_en, 64'd0);
    check("idle_flush_resp", o_resp_valid, 64'd0);

    // Asynchronous reset mid-MEM; later ack ignored
    req_valid = 1'b1; req_addr = 32'h1000; req_type = 3'b001; req_tag = 5'd15;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_reset_rd_en", o_mem_rd_en, 64'd1);
    reset = 1'b1;
    #1;
    check("areset_rd_en", o_mem_rd_en, 64'd0);
    check("areset_ready", o_req_ready, 64'd1);
    tick();
    reset = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("late_ack_resp", o_resp_valid, 64'd0);
    check("late_ack_rd_en", o_mem_rd_en, 64'd0);
    tick();
    check("late_ack_resp2", o_resp_valid, 64'd0);

    // Asynchronous reset while an exception response is pending
    req_valid = 1'b1; req_addr = 32'h1001; req_type = 3'b011; req_tag = 5'd16;
    tick();
    req_valid = 1'b0;
    check("pre_reset_exc", o_resp_exc, 64'd1);
    reset = 1'b1;
    #1;
    check("areset_exc", o_resp_exc, 64'd0);
    check("areset_valid", o_resp_valid, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Randomized loads on both widths
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      tick();
      for (int n = 0; n < 60; n++) begin
        do_load($urandom, 3'($urandom), 5'($urandom), {$urandom, $urandom},
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), got);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
